rf_fwd_stage: RTL and testbench

- Register-file and forwarding stage sitting directly upstream of the even/odd execution units (SimpleFixed2 and peers); it also consumes their writeback outputs (rt_wb, rt_addr_wb, reg_write_wb).
- Holds the 128 x 128-bit SPU register file and a short commit pipeline of in-flight results.
- Supplies forwarded operand values ra/rb/rc to the execute stage one cycle after the read addresses are presented.

---
 rtl/spu_pkg.sv | 21 ++
 rtl/rf_fwd_stage_if.sv | 36 +++
 rtl/rf_fwd_stage_fwd_select.sv | 25 ++
 rtl/rf_fwd_stage.sv | 116 +++++++++++
 tb/tb_rf_fwd_stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/spu_pkg.sv
// Shared SPU types for the register-file / forwarding stage: widths, writeback
// tuple and pipe indices.
package spu_pkg;
  localparam int REG_ADDR_W = 7;
  localparam int QUAD_W     = 128;
  localparam int EVEN       = 0;
  localparam int ODD        = 1;

  typedef struct packed {
    logic [QUAD_W-1:0]     value;
    logic [REG_ADDR_W-1:0] addr;
    logic                  we;
  } wb_t;

  // Saturating accumulate of a 0..3 operand count into a 32-bit counter.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/rf_fwd_stage_if.sv
// Operand-read and writeback bus of the register-file stage.
// Stats outputs exist only when RF_FWD_STATS_EN is defined.
interface rf_fwd_stage_if;
  import spu_pkg::*;
  logic [REG_ADDR_W-1:0] ra_addr, rb_addr, rc_addr;
  logic                  rd_valid;
  logic [QUAD_W-1:0]     ev_rt_wb, od_rt_wb;
  logic [REG_ADDR_W-1:0] ev_rt_addr_wb, od_rt_addr_wb;
  logic                  ev_reg_write_wb, od_reg_write_wb;
  logic [QUAD_W-1:0]     ra, rb, rc;
  logic                  op_valid;
  logic                  wb_collision;
`ifdef RF_FWD_STATS_EN
  logic [31:0]           fwd_hits, rf_reads;
`endif

  modport master (
    output ra_addr, rb_addr, rc_addr, rd_valid,
           ev_rt_wb, ev_rt_addr_wb, ev_reg_write_wb,
           od_rt_wb, od_rt_addr_wb, od_reg_write_wb,
    input  ra, rb, rc, op_valid, wb_collision
`ifdef RF_FWD_STATS_EN
    , input fwd_hits, rf_reads
`endif
  );

  modport slave (
    input  ra_addr, rb_addr, rc_addr, rd_valid,
           ev_rt_wb, ev_rt_addr_wb, ev_reg_write_wb,
           od_rt_wb, od_rt_addr_wb, od_reg_write_wb,
    output ra, rb, rc, op_valid, wb_collision
`ifdef RF_FWD_STATS_EN
    , output fwd_hits, rf_reads
`endif
  );
endinterface

// File: rtl/rf_fwd_stage_fwd_select.sv
// Combinational priority search for one operand: candidate 0 is highest
// priority, the array value is the fallback.
module fwd_select
  import spu_pkg::*;
#(
  parameter int NUM_CAND = 6
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  wb_t  [NUM_CAND-1:0]   cand,
  input  logic [QUAD_W-1:0]     arr_value,
  output logic [QUAD_W-1:0]     value,
  output logic                  hit
);
  // Walk from lowest to highest priority so the last match is the winner.
  always_comb begin
    value = arr_value;
    hit   = 1'b0;
    for (int i = NUM_CAND-1; i >= 0; i--) begin
      if (cand[i].we && cand[i].addr == addr) begin
        value = cand[i].value;
        hit   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_fwd_stage.sv
// SPU register file with per-pipe commit staging and operand forwarding.
// Optional RF_FWD_STATS_EN adds saturating fwd_hits / rf_reads counters.
module rf_fwd_stage
  import spu_pkg::*;
#(
  parameter int NUM_REGS     = 128,
  parameter int WIDTH        = QUAD_W,
  parameter int COMMIT_DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  rf_fwd_stage_if.slave bus
);
  localparam int NUM_CAND = 2 * (COMMIT_DEPTH + 1);

  logic [WIDTH-1:0]                 rf [NUM_REGS];
  wb_t  [1:0]                       in_wb;
  wb_t  [1:0][COMMIT_DEPTH-1:0]     slot;
  wb_t  [NUM_CAND-1:0]              cand;
  logic [2:0][REG_ADDR_W-1:0]       rd_addr;
  logic [2:0][QUAD_W-1:0]           arr_val, sel_val, op_q;
  logic [2:0]                       hit;
  logic                             op_valid_q, collision_q;
  wb_t                              cm_ev, cm_od;

  assign in_wb[EVEN] = {bus.ev_rt_wb, bus.ev_rt_addr_wb, bus.ev_reg_write_wb};
  assign in_wb[ODD]  = {bus.od_rt_wb, bus.od_rt_addr_wb, bus.od_reg_write_wb};
  assign rd_addr     = {bus.rc_addr, bus.rb_addr, bus.ra_addr};
  assign cm_ev       = slot[EVEN][COMMIT_DEPTH-1];
  assign cm_od       = slot[ODD][COMMIT_DEPTH-1];

  // Priority order: inputs, then slot 0..DEPTH-1, even before odd at each level.
  always_comb begin
    cand    = '0;
    cand[0] = in_wb[EVEN];
    cand[1] = in_wb[ODD];
    for (int k = 0; k < COMMIT_DEPTH; k++) begin
      cand[2+2*k] = slot[EVEN][k];
      cand[3+2*k] = slot[ODD][k];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_op
    assign arr_val[g] = rf[rd_addr[g]];
    fwd_select #(.NUM_CAND(NUM_CAND)) u_sel (
      .addr      (rd_addr[g]),
      .cand      (cand),
      .arr_value (arr_val[g]),
      .value     (sel_val[g]),
      .hit       (hit[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        slot[p][0] <= in_wb[p];
        for (int k = 1; k < COMMIT_DEPTH; k++) slot[p][k] <= slot[p][k-1];
      end
    end
  end

  // Odd is written first so an even write to the same address overrides it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      if (cm_od.we) rf[cm_od.addr] <= cm_od.value;
      if (cm_ev.we) rf[cm_ev.addr] <= cm_ev.value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      op_valid_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      op_valid_q  <= bus.rd_valid;
      if (bus.rd_valid) op_q <= sel_val;
      collision_q <= in_wb[EVEN].we && in_wb[ODD].we &&
                     (in_wb[EVEN].addr == in_wb[ODD].addr);
    end
  end

  assign bus.ra           = op_q[0];
  assign bus.rb           = op_q[1];
  assign bus.rc           = op_q[2];
  assign bus.op_valid     = op_valid_q;
  assign bus.wb_collision = collision_q;

`ifdef RF_FWD_STATS_EN
  logic [31:0] fwd_hits_q, rf_reads_q;
  logic [1:0]  n_hit;

  assign n_hit = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_hits_q <= '0;
      rf_reads_q <= '0;
    end else if (bus.rd_valid) begin
      fwd_hits_q <= sat_add32(fwd_hits_q, n_hit);
      rf_reads_q <= sat_add32(rf_reads_q, 2'd3 - n_hit);
    end
  end

  assign bus.fwd_hits = fwd_hits_q;
  assign bus.rf_reads = rf_reads_q;
`else
  logic unused_hit;
  assign unused_hit = ^hit;
`endif
endmodule

// File: tb/tb_rf_fwd_stage.sv
// Directed-vector bench for rf_fwd_stage (stats checks when RF_FWD_STATS_EN).
module tb_rf_fwd_stage;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [127:0] VA = {8{16'hAAAA}};
  localparam logic [127:0] V1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] V2 = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
  localparam logic [127:0] V3 = 128'h1;
  localparam logic [127:0] V4 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

  rf_fwd_stage_if bus ();

  rf_fwd_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_idle();
    bus.ev_reg_write_wb = 1'b0; bus.ev_rt_wb = '0; bus.ev_rt_addr_wb = '0;
    bus.od_reg_write_wb = 1'b0; bus.od_rt_wb = '0; bus.od_rt_addr_wb = '0;
  endtask

  task automatic ev_wr(input logic [6:0] a, input logic [127:0] v);
    bus.ev_reg_write_wb = 1'b1; bus.ev_rt_addr_wb = a; bus.ev_rt_wb = v;
  endtask

  task automatic od_wr(input logic [6:0] a, input logic [127:0] v);
    bus.od_reg_write_wb = 1'b1; bus.od_rt_addr_wb = a; bus.od_rt_wb = v;
  endtask

  task automatic rd(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    bus.ra_addr = a; bus.rb_addr = b; bus.rc_addr = c; bus.rd_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rd_valid = 1'b0; bus.ra_addr = '0; bus.rb_addr = '0; bus.rc_addr = '0;
    wb_idle();
    #3;
    vectors++; if (bus.ra !== '0) begin miscompares++; $display("FAIL reset_ra got %h want 0", bus.ra); end
    vectors++; if (bus.op_valid !== 1'b0) begin miscompares++; $display("FAIL reset_op_valid got %b want 0", bus.op_valid); end
    vectors++; if (bus.wb_collision !== 1'b0) begin miscompares++; $display("FAIL reset_collision got %b want 0", bus.wb_collision); end
`ifdef RF_FWD_STATS_EN
    vectors++; if (bus.fwd_hits !== 32'd0 || bus.rf_reads !== 32'd0) begin miscompares++; $display("FAIL reset_stats got %0d/%0d want 0/0", bus.fwd_hits, bus.rf_reads); end
`endif
    tick();
    reset = 1'b0;
    rd(7'd5, 7'd6, 7'd7);
    tick();
    vectors++; if ({bus.ra, bus.rb, bus.rc} !== '0) begin miscompares++; $display("FAIL reset_read got %h %h %h want 0", bus.ra, bus.rb, bus.rc); end
    vectors++; if (bus.op_valid !== 1'b1) begin miscompares++; $display("FAIL reset_read_valid got %b want 1", bus.op_valid); end
  endtask

  task automatic test_fwd_depth();
`ifdef RF_FWD_STATS_EN
    logic [31:0] fh0, rr0;
    fh0 = bus.fwd_hits; rr0 = bus.rf_reads;
`endif
    ev_wr(7'd3, VA);
    rd(7'd3, 7'd3, 7'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      wb_idle();
      vectors++;
      if (bus.ra !== VA || bus.rb !== VA || bus.rc !== VA) begin
        miscompares++; $display("FAIL fwd_depth_%0d got %h want %h", i, bus.ra, VA);
      end
`ifdef RF_FWD_STATS_EN
      if (i == 2) begin
        vectors++; if (bus.fwd_hits - fh0 !== 32'd9 || bus.rf_reads - rr0 !== 32'd0) begin
          miscompares++; $display("FAIL stats_fwd got %0d/%0d want 9/0", bus.fwd_hits - fh0, bus.rf_reads - rr0); end
      end
`endif
    end
`ifdef RF_FWD_STATS_EN
    vectors++; if (bus.fwd_hits - fh0 !== 32'd9 || bus.rf_reads - rr0 !== 32'd3) begin
      miscompares++; $display("FAIL stats_array got %0d/%0d want 9/3", bus.fwd_hits - fh0, bus.rf_reads - rr0); end
`endif
  endtask

  task automatic test_operands();
    bus.rd_valid = 1'b0;
    ev_wr(7'd40, V1); od_wr(7'd41, V2);
    tick();
    ev_wr(7'd42, V3); od_wr(7'd0, V4);
    tick();
    wb_idle();
    repeat (3) tick();
    rd(7'd40, 7'd41, 7'd42);
    tick();
    vectors++; if (bus.ra !== V1 || bus.rb !== V2 || bus.rc !== V3) begin
      miscompares++; $display("FAIL operands got %h %h %h want %h %h %h", bus.ra, bus.rb, bus.rc, V1, V2, V3); end
    rd(7'd0, 7'd40, 7'd1);
    tick();
    vectors++; if (bus.ra !== V4 || bus.rb !== V1 || bus.rc !== '0) begin
      miscompares++; $display("FAIL reg0 got %h %h %h want %h %h 0", bus.ra, bus.rb, bus.rc, V4, V1); end
  endtask

  task automatic test_newest();
    bus.rd_valid = 1'b0;
    ev_wr(7'd9, 128'h11);
    tick();
    ev_wr(7'd9, 128'h22);
    rd(7'd9, 7'd9, 7'd9);
    tick();
    wb_idle();
    vectors++; if (bus.ra !== 128'h22) begin miscompares++; $display("FAIL newest got %h want 22", bus.ra); end
    bus.rd_valid = 1'b0;
    repeat (3) tick();
    rd(7'd9, 7'd9, 7'd9);
    tick();
    vectors++; if (bus.rb !== 128'h22) begin miscompares++; $display("FAIL newest_array got %h want 22", bus.rb); end
  endtask

  task automatic test_collision();
    ev_wr(7'd12, 128'hE); od_wr(7'd12, 128'h0);
    rd(7'd12, 7'd12, 7'd12);
    tick();
    wb_idle();
    vectors++; if (bus.wb_collision !== 1'b1) begin miscompares++; $display("FAIL collision_pulse got %b want 1", bus.wb_collision); end
    vectors++; if (bus.ra !== 128'hE) begin miscompares++; $display("FAIL collision_fwd got %h want e", bus.ra); end
    tick();
    vectors++; if (bus.wb_collision !== 1'b0) begin miscompares++; $display("FAIL collision_end got %b want 0", bus.wb_collision); end
    ev_wr(7'd13, 128'h5); od_wr(7'd14, 128'h6);
    tick();
    wb_idle();
    vectors++; if (bus.wb_collision !== 1'b0) begin miscompares++; $display("FAIL collision_diff got %b want 0", bus.wb_collision); end
    repeat (3) tick();
    vectors++; if (bus.ra !== 128'hE) begin miscompares++; $display("FAIL collision_array got %h want e", bus.ra); end
  endtask

  task automatic test_hold();
    rd(7'd3, 7'd9, 7'd12);
    tick();
    vectors++; if (bus.ra !== VA || bus.rb !== 128'h22 || bus.rc !== 128'hE) begin
      miscompares++; $display("FAIL hold_setup got %h %h %h", bus.ra, bus.rb, bus.rc); end
    bus.rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev_wr(7'd3, 128'h77 + 128'(i)); od_wr(7'd9, 128'h99);
      tick();
      vectors++;
      if (bus.ra !== VA || bus.rb !== 128'h22 || bus.rc !== 128'hE || bus.op_valid !== 1'b0) begin
        miscompares++; $display("FAIL hold_%0d got %h %h %h v=%b", i, bus.ra, bus.rb, bus.rc, bus.op_valid); end
    end
    wb_idle();
    rd(7'd3, 7'd9, 7'd12);
    tick();
    vectors++; if (bus.ra !== 128'h79 || bus.rb !== 128'h99 || bus.op_valid !== 1'b1) begin
      miscompares++; $display("FAIL hold_resume got %h %h v=%b want 79 99 1", bus.ra, bus.rb, bus.op_valid); end
  endtask

  task automatic test_reset_discard();
    bus.rd_valid = 1'b0;
    ev_wr(7'd20, 128'h55);
    tick();
    wb_idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    rd(7'd20, 7'd3, 7'd20);
    tick();
    vectors++; if (bus.ra !== '0 || bus.rb !== '0) begin
      miscompares++; $display("FAIL reset_discard got %h %h want 0 0", bus.ra, bus.rb); end
    bus.rd_valid = 1'b0;
    repeat (3) tick();
    rd(7'd20, 7'd20, 7'd20);
    tick();
    vectors++; if (bus.rc !== '0) begin miscompares++; $display("FAIL reset_discard_late got %h want 0", bus.rc); end
  endtask

  initial begin
    test_reset();
    test_fwd_depth();
    test_operands();
    test_newest();
    test_collision();
    test_hold();
    test_reset_discard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
